// File: rtl/gray_conv_arbiter.sv
// Round-robin shared binary<->Gray converter with a valid/ready response port.
// Define GRAY_CONV_ARB_STATS_EN to add per-requester saturating grant counters (stat_grants).
module gray_conv_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  parameter int ID_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_mode,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     rsp_mode
`ifdef GRAY_CONV_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]      stat_grants
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, RESP = 2'd2} state_t;

  state_t              state_r;
  logic [ID_W-1:0]     rr_ptr_r;
  logic [CW-1:0]       bit_r;
  logic [WIDTH-1:0]    op_r;
  logic                rsp_valid_r;
  logic [WIDTH-1:0]    rsp_data_r;
  logic [ID_W-1:0]     rsp_id_r;
  logic                rsp_mode_r;

  logic                gnt_found_s;
  logic [ID_W-1:0]     gnt_idx_s;
  logic [N_REQ-1:0]    vsh_s;
  logic [N_REQ*WIDTH-1:0] dsh_s;
  logic [N_REQ-1:0]    msh_s;
  logic [WIDTH-1:0]    gnt_op_s;
  logic                gnt_mode_s;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx         = 0;
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    vsh_s       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(rr_ptr_r) + i;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end else begin
        idx = idx;
      end
      vsh_s = req_valid >> idx;
      if (!gnt_found_s && vsh_s[0]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = ID_W'(idx);
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  // Select the granted requester's operand and direction.
  always_comb begin
    dsh_s      = req_data >> (int'(gnt_idx_s) * WIDTH);
    msh_s      = req_mode >> gnt_idx_s;
    gnt_op_s   = dsh_s[WIDTH-1:0];
    gnt_mode_s = msh_s[0];
    if (state_r == IDLE && !rst && gnt_found_s) begin
      req_ready = N_REQ'(1) << gnt_idx_s;
    end else begin
      req_ready = '0;
    end
  end

  // Control FSM; the response register doubles as the bit-serial accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      rr_ptr_r    <= '0;
      bit_r       <= '0;
      op_r        <= '0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= '0;
      rsp_id_r    <= '0;
      rsp_mode_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (gnt_found_s) begin
            op_r       <= gnt_op_s;
            rsp_mode_r <= gnt_mode_s;
            rsp_id_r   <= gnt_idx_s;
            rsp_data_r <= {gnt_op_s[WIDTH-1], {(WIDTH-1){1'b0}}};
            bit_r      <= CW'(WIDTH - 2);
            state_r    <= CONV;
          end else begin
            state_r <= IDLE;
          end
        end
        CONV: begin
          if (!rsp_mode_r) begin
            rsp_data_r  <= op_r ^ (op_r >> 1);
            rsp_valid_r <= 1'b1;
            state_r     <= RESP;
          end else begin
            // Resolve one lower bit per cycle from the bit above it.
            rsp_data_r[bit_r] <= rsp_data_r[bit_r + CW'(1)] ^ op_r[bit_r];
            if (bit_r == CW'(0)) begin
              rsp_valid_r <= 1'b1;
              state_r     <= RESP;
            end else begin
              bit_r <= bit_r - CW'(1);
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= IDLE;
            if (int'(rsp_id_r) == N_REQ - 1) begin
              rr_ptr_r <= '0;
            end else begin
              rr_ptr_r <= rsp_id_r + ID_W'(1);
            end
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          state_r     <= IDLE;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_mode  = rsp_mode_r;

`ifdef GRAY_CONV_ARB_STATS_EN
  logic [15:0] cnt_r [N_REQ];

  // Saturating per-requester grant counters.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (rst) begin
        cnt_r[i] <= 16'd0;
      end else if (state_r == IDLE && gnt_found_s && gnt_idx_s == ID_W'(i) && cnt_r[i] != 16'hFFFF) begin
        cnt_r[i] <= cnt_r[i] + 16'd1;
      end else begin
        cnt_r[i] <= cnt_r[i];
      end
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_stat
    assign stat_grants[g*16 +: 16] = cnt_r[g];
  end
`endif

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed self-checking bench for gray_conv_arbiter using a response scoreboard.
module tb_gray_conv_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_mode;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic        rsp_mode;
`ifdef GRAY_CONV_ARB_STATS_EN
  logic [63:0] stat_grants;
`endif

  typedef struct {
    logic [3:0] data;
    logic [1:0] id;
    logic       mode;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  gray_conv_arbiter #(.N_REQ(4), .WIDTH(4), .ID_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_mode  (req_mode),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_mode  (rsp_mode)
`ifdef GRAY_CONV_ARB_STATS_EN
    ,
    .stat_grants (stat_grants)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] b2g(input logic [3:0] d);
    return d ^ {1'b0, d[3:1]};
  endfunction

  // Each binary bit is the parity of all Gray bits at or above it.
  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    logic [3:0] s;
    for (int i = 0; i < 4; i++) begin
      s    = g >> i;
      b[i] = ^s;
    end
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input int id, input logic mode, input logic [3:0] d);
    exp_t e;
    e.id   = 2'(id);
    e.mode = mode;
    e.data = mode ? g2b(d) : b2g(d);
    return e;
  endfunction

  // Called just after the grant edge; returns at the negedge of the first valid response cycle.
  task automatic wait_rsp(input int exp_lat);
    int   lat;
    bit   got;
    exp_t e;
    lat = 1;
    got = 1'b0;
    while (!got && lat <= 20) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
      end else begin
        lat++;
        @(posedge clk); #1;
      end
    end
    chk("latency", lat, exp_lat);
    if (got) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_mode", rsp_mode, e.mode);
      end else begin
        chk("sb_nonempty", 32'd0, 32'd1);
      end
    end
  endtask

  // Called just after a posedge with the DUT idle; one full transaction with rsp_ready high.
  task automatic run_one(input logic [3:0] mask, input int id, input logic mode,
                         input logic [3:0] d, input int exp_lat);
    logic [3:0] g;
    g = 4'b0001 << id;
    req_valid = mask;
    req_mode[id] = mode;
    req_data[id*4 +: 4] = d;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("grant", req_ready, g);
    sb.push_back(mk(id, mode, d));
    @(posedge clk); #1;
    req_valid = 4'b0000;
    wait_rsp(exp_lat);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [3:0] rr_data [4];
    int         rr_exp;
    rr_data = '{4'h3, 4'h6, 4'h9, 4'hC};

    rst = 1'b1;
    req_valid = 4'b1111;
    req_mode = 4'b0000;
    req_data = 16'h0000;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 4'h0);
    chk("rst_rsp_id", rsp_id, 2'd0);
    chk("rst_rsp_mode", rsp_mode, 1'b0);
    chk("rst_req_ready", req_ready, 4'b0000);
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 4'b0000;

    run_one(4'b0010, 1, 1'b0, 4'b0111, 2);
    run_one(4'b0100, 2, 1'b1, 4'b1101, 4);
    run_one(4'b0100, 2, 1'b1, 4'b1111, 4);
    run_one(4'b1000, 3, 1'b0, 4'b0000, 2);
    run_one(4'b0001, 0, 1'b0, 4'b1111, 2);

    // Round robin with everyone requesting: order 1,2,3,0,1 from rr_ptr = 1.
    req_valid = 4'b1111;
    req_mode = 4'b0000;
    for (int i = 0; i < 4; i++) req_data[i*4 +: 4] = rr_data[i];
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      rr_exp = (k + 1) % 4;
      @(negedge clk);
      chk("rr_grant", req_ready, 4'b0001 << rr_exp);
      chk("rr_onehot", 32'($onehot(req_ready)), 32'd1);
      sb.push_back(mk(rr_exp, 1'b0, rr_data[rr_exp]));
      @(posedge clk); #1;
      wait_rsp(2);
      @(posedge clk); #1;
    end
    req_valid = 4'b0000;

    // Stalled response while other requests pend (rr_ptr = 2 now); serve 2 first to reach 1 via 3,0.
    run_one(4'b0100, 2, 1'b0, 4'h1, 2);
    run_one(4'b1000, 3, 1'b0, 4'h2, 2);
    run_one(4'b0001, 0, 1'b0, 4'h4, 2);
    req_valid = 4'b0010;
    req_mode[1] = 1'b0;
    req_data[7:4] = 4'hF;
    @(negedge clk);
    chk("stall_grant", req_ready, 4'b0010);
    sb.push_back(mk(1, 1'b0, 4'hF));
    @(posedge clk); #1;
    req_valid = 4'b1101;
    req_mode[2] = 1'b1;
    req_data[11:8] = 4'hA;
    rsp_ready = 1'b0;
    wait_rsp(2);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("stall_valid", rsp_valid, 1'b1);
      chk("stall_data", rsp_data, 4'b1000);
      chk("stall_ready", req_ready, 4'b0000);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_stall_grant", req_ready, 4'b0100);
    sb.push_back(mk(2, 1'b1, 4'hA));
    @(posedge clk); #1;
    req_valid = 4'b0000;
    wait_rsp(4);
    @(posedge clk); #1;

    // Reset during the second CONV cycle of a Gray->binary request (rr_ptr = 3 here).
    req_valid = 4'b0100;
    req_mode[2] = 1'b1;
    req_data[11:8] = 4'b1101;
    @(negedge clk);
    chk("abort_grant", req_ready, 4'b0100);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_rsp_valid", rsp_valid, 1'b0);
    chk("abort_rsp_data", rsp_data, 4'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort_quiet", rsp_valid, 1'b0);
    end
    @(posedge clk); #1;
    run_one(4'b1010, 1, 1'b0, 4'h5, 2);
    run_one(4'b1000, 3, 1'b1, 4'b0110, 4);

`ifdef GRAY_CONV_ARB_STATS_EN
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("stat_clear", stat_grants, 32'd0);
    @(posedge clk); #1;
    run_one(4'b0001, 0, 1'b0, 4'h1, 2);
    run_one(4'b0001, 0, 1'b0, 4'h2, 2);
    run_one(4'b0001, 0, 1'b1, 4'h3, 4);
    run_one(4'b0100, 2, 1'b0, 4'h4, 2);
    @(negedge clk);
    chk("stat0", stat_grants[15:0], 16'd3);
    chk("stat1", stat_grants[31:16], 16'd0);
    chk("stat2", stat_grants[47:32], 16'd1);
    chk("stat3", stat_grants[63:48], 16'd0);
`endif

    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
